// File: rtl/clock_set_ctrl.sv
// ============================================================================
// clock_set_ctrl
// ----------------------------------------------------------------------------
// Run/set sequencer for a six-digit BCD 24-hour time counter (HH:MM:SS).
//
// In RUN the block forwards the external 1 Hz tick to the counter as a
// registered count enable and shows the live counter digits. A mode press
// snapshots the live time into local edit registers. The user then edits
// hours, minutes and seconds in turn. A final mode press issues a one-cycle
// parallel load back into the counter. While editing, the selected field
// blinks on the display. Inactivity aborts the edit after TIMEOUT_TICKS
// seconds with no button press.
//
// Parameters:
//   TIMEOUT_TICKS  tick_1hz pulses without a press before SET aborts (1..255)
//   BLINK_EN       1 = blank the edited field while blink_phase is high
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   tick_1hz               one-clk pulse per second
//   btn_mode               enter set mode / advance to next field
//   btn_inc, btn_dec       increment / decrement the selected field
//   live_d0..live_d5       live counter digits (d0 = sec units, d5 = hr tens)
//   count_en               registered increment enable to the counter
//   load                   one-cycle parallel-load strobe to the counter
//   load_d0..load_d5       BCD digits accompanying load
//   disp_d0..disp_d5       digits to display, 4'hF = blank
//   set_field              0 = RUN (also during LOAD), 1 = HR, 2 = MIN, 3 = SEC
//
// Strobe protocol: every input event (tick_1hz, btn_*) is a single-cycle
// pulse that is consumed in the cycle it is high; there is no back-pressure.
// On the output side load is a single-cycle strobe, and load_d* is stable in
// that cycle and holds its value afterwards; the counter must accept it in
// that cycle.
//
// All outputs are registered. They are computed from the next-state values,
// so in every cycle they agree with the state that is currently held, and
// set_field doubles as the externally visible view of the FSM state.
// ============================================================================
module clock_set_ctrl #(
    parameter int unsigned TIMEOUT_TICKS = 10,
    parameter bit          BLINK_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [3:0] live_d0,
    input  logic [3:0] live_d1,
    input  logic [3:0] live_d2,
    input  logic [3:0] live_d3,
    input  logic [3:0] live_d4,
    input  logic [3:0] live_d5,
    output logic       count_en,
    output logic       load,
    output logic [3:0] load_d0,
    output logic [3:0] load_d1,
    output logic [3:0] load_d2,
    output logic [3:0] load_d3,
    output logic [3:0] load_d4,
    output logic [3:0] load_d5,
    output logic [3:0] disp_d0,
    output logic [3:0] disp_d1,
    output logic [3:0] disp_d2,
    output logic [3:0] disp_d3,
    output logic [3:0] disp_d4,
    output logic [3:0] disp_d5,
    output logic [1:0] set_field
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_TICKS);
    localparam logic [7:0] HR_MAX   = 8'h23;
    localparam logic [7:0] MS_MAX   = 8'h59;

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_SET_HR  = 3'd1,
        S_SET_MIN = 3'd2,
        S_SET_SEC = 3'd3,
        S_LOAD    = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // One BCD step of a two-digit field that counts 00..max_val.
    // Any non-BCD digit collapses the field to 00 on the first step.
    // A valid-BCD value above max_val (e.g. hours 25 captured from a bad
    // counter) goes to 00 on increment and to max_val on decrement, so the
    // field is always back in range after one press.
    // ------------------------------------------------------------------------
    function automatic logic [7:0] bcd_step(input logic [7:0] val,
                                            input logic [7:0] max_val,
                                            input logic       up);
        logic [3:0] tens;
        logic [3:0] units;
        logic [7:0] res;
        tens  = val[7:4];
        units = val[3:0];
        if (tens > 4'd9 || units > 4'd9) begin
            res = 8'h00;
        end else if (up) begin
            if (val >= max_val) begin
                res = 8'h00;
            end else if (units == 4'd9) begin
                res = {tens + 4'd1, 4'd0};
            end else begin
                res = {tens, units + 4'd1};
            end
        end else begin
            if (val == 8'h00 || val > max_val) begin
                res = max_val;
            end else if (units == 4'd0) begin
                res = {tens - 4'd1, 4'd9};
            end else begin
                res = {tens, units - 4'd1};
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    state_t          state_q;
    logic [5:0][3:0] edit_q;       // [5]=hr tens ... [0]=sec units
    logic [7:0]      to_q;         // ticks since last press / SET entry
    logic            blink_q;
    logic            count_en_q;
    logic            load_q;
    logic [5:0][3:0] load_d_q;
    logic [5:0][3:0] disp_q;
    logic [1:0]      set_field_q;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [5:0][3:0] live;
    state_t          state_n;
    logic [5:0][3:0] edit_n;
    logic [7:0]      to_n;
    logic [7:0]      to_inc;
    logic            blink_n;
    logic            count_en_n;
    logic            load_n;
    logic [5:0][3:0] load_d_n;
    logic [5:0][3:0] disp_n;
    logic [1:0]      set_field_n;
    logic [7:0]      sel_val;
    logic [7:0]      sel_max;
    logic [7:0]      sel_new;
    logic            in_set;
    logic            next_in_set;

    assign live = {live_d5, live_d4, live_d3, live_d2, live_d1, live_d0};

    always_comb begin
        state_n     = state_q;
        edit_n      = edit_q;
        to_n        = to_q;
        to_inc      = to_q + 8'd1;
        count_en_n  = 1'b0;
        sel_val     = edit_q[1:0];
        sel_max     = MS_MAX;

        // Field currently addressed by inc/dec.
        case (state_q)
            S_SET_HR: begin
                sel_val = edit_q[5:4];
                sel_max = HR_MAX;
            end
            S_SET_MIN: begin
                sel_val = edit_q[3:2];
                sel_max = MS_MAX;
            end
            default: begin
                sel_val = edit_q[1:0];
                sel_max = MS_MAX;
            end
        endcase
        sel_new = bcd_step(sel_val, sel_max, btn_inc);

        in_set = (state_q == S_SET_HR) || (state_q == S_SET_MIN) ||
                 (state_q == S_SET_SEC);

        case (state_q)
            S_RUN: begin
                // A tick coinciding with the mode press is dropped: the
                // snapshot is taken before that second would be counted.
                count_en_n = tick_1hz & ~btn_mode;
                if (btn_mode) begin
                    edit_n  = live;
                    state_n = S_SET_HR;
                    to_n    = 8'd0;
                end
            end

            S_SET_HR, S_SET_MIN, S_SET_SEC: begin
                // Priority: mode > inc/dec > timeout tick. Any press
                // restarts the inactivity window.
                if (btn_mode) begin
                    to_n = 8'd0;
                    case (state_q)
                        S_SET_HR:  state_n = S_SET_MIN;
                        S_SET_MIN: state_n = S_SET_SEC;
                        default:   state_n = S_LOAD;
                    endcase
                end else if (btn_inc || btn_dec) begin
                    to_n = 8'd0;
                    // inc and dec together cancel out.
                    if (btn_inc ^ btn_dec) begin
                        case (state_q)
                            S_SET_HR:  edit_n[5:4] = sel_new;
                            S_SET_MIN: edit_n[3:2] = sel_new;
                            default:   edit_n[1:0] = sel_new;
                        endcase
                    end
                end else if (tick_1hz) begin
                    if (to_inc == TO_LIMIT) begin
                        state_n = S_RUN;
                        to_n    = 8'd0;
                    end else begin
                        to_n = to_inc;
                    end
                end
            end

            S_LOAD: begin
                state_n = S_RUN;
                to_n    = 8'd0;
            end

            default: begin
                state_n = S_RUN;
                to_n    = 8'd0;
            end
        endcase

        next_in_set = (state_n == S_SET_HR) || (state_n == S_SET_MIN) ||
                      (state_n == S_SET_SEC);

        // Blink runs only while staying inside the SET states; it restarts
        // from 0 on every entry.
        blink_n = (in_set && next_in_set) ? (blink_q ^ tick_1hz) : 1'b0;

        load_n   = (state_n == S_LOAD);
        load_d_n = load_n ? edit_n : load_d_q;

        case (state_n)
            S_SET_HR:  set_field_n = 2'd1;
            S_SET_MIN: set_field_n = 2'd2;
            S_SET_SEC: set_field_n = 2'd3;
            default:   set_field_n = 2'd0;
        endcase

        disp_n = (state_n == S_RUN) ? live : edit_n;
        if (BLINK_EN && blink_n) begin
            case (state_n)
                S_SET_HR:  disp_n[5:4] = 8'hFF;
                S_SET_MIN: disp_n[3:2] = 8'hFF;
                S_SET_SEC: disp_n[1:0] = 8'hFF;
                default:   disp_n      = disp_n;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            edit_q      <= '0;
            to_q        <= 8'd0;
            blink_q     <= 1'b0;
            count_en_q  <= 1'b0;
            load_q      <= 1'b0;
            load_d_q    <= '0;
            disp_q      <= '0;
            set_field_q <= 2'd0;
        end else begin
            state_q     <= state_n;
            edit_q      <= edit_n;
            to_q        <= to_n;
            blink_q     <= blink_n;
            count_en_q  <= count_en_n;
            load_q      <= load_n;
            load_d_q    <= load_d_n;
            disp_q      <= disp_n;
            set_field_q <= set_field_n;
        end
    end

    assign count_en  = count_en_q;
    assign load      = load_q;
    assign set_field = set_field_q;

    assign load_d0 = load_d_q[0];
    assign load_d1 = load_d_q[1];
    assign load_d2 = load_d_q[2];
    assign load_d3 = load_d_q[3];
    assign load_d4 = load_d_q[4];
    assign load_d5 = load_d_q[5];

    assign disp_d0 = disp_q[0];
    assign disp_d1 = disp_q[1];
    assign disp_d2 = disp_q[2];
    assign disp_d3 = disp_q[3];
    assign disp_d4 = disp_q[4];
    assign disp_d5 = disp_q[5];

endmodule

// File: tb/tb_clock_set_ctrl.sv
// ============================================================================
// tb_clock_set_ctrl
// ----------------------------------------------------------------------------
// Two instances share all inputs: dut_a (TIMEOUT_TICKS=10, BLINK_EN=1) and
// dut_b (TIMEOUT_TICKS=5, BLINK_EN=0). A per-instance reference model works
// on whole-field integers (hours 0..23, minutes/seconds 0..59) with modular
// arithmetic and predicts the full output vector every cycle. Directed
// scenarios add checks against hand-computed constants; an expected queue
// tracks load values for dut_a.
// ============================================================================
module tb_clock_set_ctrl;

    localparam int TO_A = 10;
    localparam int TO_B = 5;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic clk      = 1'b0;
    logic rst_n    = 1'b1;
    logic tick_1hz = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_inc  = 1'b0;
    logic btn_dec  = 1'b0;
    logic [3:0] live [6];

    always #5 clk = ~clk;

    logic       a_cen, a_ld, b_cen, b_ld;
    logic [1:0] a_sf, b_sf;
    logic [3:0] a_ldd [6];
    logic [3:0] a_dsp [6];
    logic [3:0] b_ldd [6];
    logic [3:0] b_dsp [6];

    clock_set_ctrl #(.TIMEOUT_TICKS(TO_A), .BLINK_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .live_d0(live[0]), .live_d1(live[1]), .live_d2(live[2]),
        .live_d3(live[3]), .live_d4(live[4]), .live_d5(live[5]),
        .count_en(a_cen), .load(a_ld),
        .load_d0(a_ldd[0]), .load_d1(a_ldd[1]), .load_d2(a_ldd[2]),
        .load_d3(a_ldd[3]), .load_d4(a_ldd[4]), .load_d5(a_ldd[5]),
        .disp_d0(a_dsp[0]), .disp_d1(a_dsp[1]), .disp_d2(a_dsp[2]),
        .disp_d3(a_dsp[3]), .disp_d4(a_dsp[4]), .disp_d5(a_dsp[5]),
        .set_field(a_sf)
    );

    clock_set_ctrl #(.TIMEOUT_TICKS(TO_B), .BLINK_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .live_d0(live[0]), .live_d1(live[1]), .live_d2(live[2]),
        .live_d3(live[3]), .live_d4(live[4]), .live_d5(live[5]),
        .count_en(b_cen), .load(b_ld),
        .load_d0(b_ldd[0]), .load_d1(b_ldd[1]), .load_d2(b_ldd[2]),
        .load_d3(b_ldd[3]), .load_d4(b_ldd[4]), .load_d5(b_ldd[5]),
        .disp_d0(b_dsp[0]), .disp_d1(b_dsp[1]), .disp_d2(b_dsp[2]),
        .disp_d3(b_dsp[3]), .disp_d4(b_dsp[4]), .disp_d5(b_dsp[5]),
        .set_field(b_sf)
    );

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          load_cnt = 0;
    logic [23:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: mode 0=RUN 1=HR 2=MIN 3=SEC 4=LOAD, digits as ints
    // ------------------------------------------------------------------------
    int m_st   [2];
    int m_ed   [2][6];
    int m_to   [2];
    bit m_blink[2];
    bit m_cen  [2];
    bit m_ld   [2];
    int m_ldd  [2][6];
    bit m_rst  [2];

    function automatic int field_val(input int tens, input int units);
        if (tens > 9 || units > 9) return -1;
        return tens * 10 + units;
    endfunction

    task automatic model_reset(input int k);
        m_st[k] = 0; m_to[k] = 0; m_blink[k] = 0; m_cen[k] = 0;
        m_ld[k] = 0; m_rst[k] = 1;
        for (int i = 0; i < 6; i++) begin
            m_ed[k][i]  = 0;
            m_ldd[k][i] = 0;
        end
    endtask

    task automatic model_step(input int k, input int limit);
        int old_st, ti, ui, lim, v;
        logic [23:0] e;
        if (!rst_n) begin
            model_reset(k);
            return;
        end
        m_rst[k] = 0;
        old_st   = m_st[k];
        m_cen[k] = 0;
        if (old_st == 0) begin
            m_cen[k] = tick_1hz && !btn_mode;
            if (btn_mode) begin
                for (int i = 0; i < 6; i++) m_ed[k][i] = int'(live[i]);
                m_st[k] = 1;
                m_to[k] = 0;
            end
        end else if (old_st <= 3) begin
            if (btn_mode) begin
                m_st[k] = old_st + 1;
                m_to[k] = 0;
            end else if (btn_inc || btn_dec) begin
                m_to[k] = 0;
                if (btn_inc != btn_dec) begin
                    ti  = 7 - 2 * old_st;
                    ui  = 6 - 2 * old_st;
                    lim = (old_st == 1) ? 23 : 59;
                    v   = field_val(m_ed[k][ti], m_ed[k][ui]);
                    if (v < 0)        v = 0;
                    else if (btn_inc) v = (v > lim) ? 0 : (v + 1) % (lim + 1);
                    else              v = (v > lim) ? lim : (v + lim) % (lim + 1);
                    m_ed[k][ti] = v / 10;
                    m_ed[k][ui] = v % 10;
                end
            end else if (tick_1hz) begin
                m_to[k]++;
                if (m_to[k] >= limit) begin
                    m_st[k] = 0;
                    m_to[k] = 0;
                end
            end
        end else begin
            m_st[k] = 0;
            m_to[k] = 0;
        end
        if (old_st >= 1 && old_st <= 3 && m_st[k] >= 1 && m_st[k] <= 3)
            m_blink[k] = m_blink[k] ^ tick_1hz;
        else
            m_blink[k] = 0;
        m_ld[k] = (m_st[k] == 4);
        if (m_ld[k]) begin
            for (int i = 0; i < 6; i++) begin
                m_ldd[k][i] = m_ed[k][i];
                e[4*i +: 4] = 4'(m_ed[k][i]);
            end
            if (k == 0) exp_q.push_back(e);
        end
    endtask

    function automatic logic [51:0] exp_vec(input int k, input bit blink_en);
        logic [51:0] v;
        int st;
        v = '0;
        if (m_rst[k]) return v;
        st = m_st[k];
        v[51:50] = (st >= 1 && st <= 3) ? 2'(st) : 2'd0;
        v[49]    = m_cen[k];
        v[48]    = m_ld[k];
        for (int i = 0; i < 6; i++) begin
            v[24+4*i +: 4] = 4'(m_ldd[k][i]);
            if (st == 0)
                v[4*i +: 4] = live[i];
            else if (blink_en && m_blink[k] && st <= 3 &&
                     (i == 7 - 2 * st || i == 6 - 2 * st))
                v[4*i +: 4] = 4'hF;
            else
                v[4*i +: 4] = 4'(m_ed[k][i]);
        end
        return v;
    endfunction

    function automatic logic [51:0] vec_a();
        logic [51:0] v;
        v = '0;
        v[51:50] = a_sf; v[49] = a_cen; v[48] = a_ld;
        for (int i = 0; i < 6; i++) begin
            v[24+4*i +: 4] = a_ldd[i];
            v[4*i +: 4]    = a_dsp[i];
        end
        return v;
    endfunction

    function automatic logic [51:0] vec_b();
        logic [51:0] v;
        v = '0;
        v[51:50] = b_sf; v[49] = b_cen; v[48] = b_ld;
        for (int i = 0; i < 6; i++) begin
            v[24+4*i +: 4] = b_ldd[i];
            v[4*i +: 4]    = b_dsp[i];
        end
        return v;
    endfunction

    function automatic logic [23:0] a_disp24();
        return {a_dsp[5], a_dsp[4], a_dsp[3], a_dsp[2], a_dsp[1], a_dsp[0]};
    endfunction

    function automatic logic [23:0] b_disp24();
        return {b_dsp[5], b_dsp[4], b_dsp[3], b_dsp[2], b_dsp[1], b_dsp[0]};
    endfunction

    function automatic logic [23:0] a_load24();
        return {a_ldd[5], a_ldd[4], a_ldd[3], a_ldd[2], a_ldd[1], a_ldd[0]};
    endfunction

    // ------------------------------------------------------------------------
    // Driver tasks (called at posedge+1, return at posedge+1)
    // ------------------------------------------------------------------------
    task automatic set_live(input int h, input int m, input int s);
        live[5] = 4'(h / 10); live[4] = 4'(h % 10);
        live[3] = 4'(m / 10); live[2] = 4'(m % 10);
        live[1] = 4'(s / 10); live[0] = 4'(s % 10);
    endtask

    task automatic step(input bit t, input bit m, input bit i, input bit d);
        logic [23:0] e;
        tick_1hz = t; btn_mode = m; btn_inc = i; btn_dec = d;
        @(posedge clk);
        model_step(0, TO_A);
        model_step(1, TO_B);
        #1;
        check("vec_a", 64'(vec_a()), 64'(exp_vec(0, 1'b1)));
        check("vec_b", 64'(vec_b()), 64'(exp_vec(1, 1'b0)));
        if (a_ld) begin
            load_cnt++;
            if (exp_q.size() == 0) begin
                check("load_unexpected", 64'(a_ld), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("load_sb", 64'(a_load24()), 64'(e));
            end
        end
        tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check("async_rst_a", 64'(vec_a()), 64'(exp_vec(0, 1'b1)));
        check("async_rst_b", 64'(vec_b()), 64'(exp_vec(1, 1'b0)));
    endtask

    task automatic do_reset();
        async_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0);
    endtask

    task automatic tick_pairs(input int n);
        for (int j = 0; j < n; j++) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int lc;
        set_live(12, 34, 56);
        model_reset(0);
        model_reset(1);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_vec_a", 64'(vec_a()), 64'd0);

        // Reset held with ticks running, then release.
        for (int j = 0; j < 6; j++) begin
            step(j % 2 == 0, 0, 0, 0);
            check("rst_count_en", 64'(a_cen), 64'd0);
            check("rst_load", 64'(a_ld), 64'd0);
        end
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        check("run_disp_live", 64'(a_disp24()), 64'h123456);
        step(1, 0, 0, 0);
        check("count_en_tick", 64'(a_cen), 64'd1);
        step(0, 0, 0, 0);
        check("count_en_idle", 64'(a_cen), 64'd0);

        // Main edit sequence: 12:34:56 -> 01:59:00.
        do_reset();
        lc = load_cnt;
        step(0, 1, 0, 0);
        check("enter_set_hr", 64'(a_sf), 64'd1);
        check("snapshot", 64'(a_disp24()), 64'h123456);
        repeat (13) step(0, 0, 1, 0);
        check("hr_inc13", 64'({a_dsp[5], a_dsp[4]}), 64'h01);
        step(0, 1, 0, 0);
        repeat (35) step(0, 0, 0, 1);
        check("min_dec35", 64'({a_dsp[3], a_dsp[2]}), 64'h59);
        step(0, 1, 0, 0);
        repeat (4) step(0, 0, 1, 0);
        check("sec_inc4", 64'({a_dsp[1], a_dsp[0]}), 64'h00);
        step(0, 1, 0, 0);
        check("load_pulse", 64'(a_ld), 64'd1);
        check("load_value", 64'(a_load24()), 64'h015900);
        check("load_count_en", 64'(a_cen), 64'd0);
        step(0, 0, 0, 0);
        check("load_done", 64'(a_ld), 64'd0);
        check("back_to_run", 64'(a_sf), 64'd0);
        step(0, 0, 0, 0);
        check("one_load_pulse", 64'(load_cnt - lc), 64'd1);

        // Wrap boundaries.
        do_reset();
        set_live(23, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        check("hr_23_inc", 64'({a_dsp[5], a_dsp[4]}), 64'h00);
        step(0, 0, 0, 1);
        check("hr_00_dec", 64'({a_dsp[5], a_dsp[4]}), 64'h23);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        check("min_00_dec", 64'({a_dsp[3], a_dsp[2]}), 64'h59);
        step(0, 0, 1, 0);
        check("min_59_inc", 64'({a_dsp[3], a_dsp[2]}), 64'h00);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        check("sec_00_dec", 64'({a_dsp[1], a_dsp[0]}), 64'h59);
        step(0, 1, 0, 0);
        check("wrap_load_value", 64'(a_load24()), 64'h230059);

        // Inactivity timeout in SET_MIN.
        do_reset();
        set_live(12, 34, 56);
        lc = load_cnt;
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        tick_pairs(9);
        check("to_9_ticks", 64'(a_sf), 64'd2);
        step(0, 0, 1, 0);
        tick_pairs(9);
        check("to_after_inc", 64'(a_sf), 64'd2);
        step(1, 0, 1, 0);
        check("to_btn_wins", 64'(a_sf), 64'd2);
        tick_pairs(9);
        check("to_9_again", 64'(a_sf), 64'd2);
        step(1, 0, 0, 0);
        check("to_expired", 64'(a_sf), 64'd0);
        check("to_no_load", 64'(load_cnt - lc), 64'd0);
        check("to_disp_live", 64'(a_disp24()), 64'h123456);

        // Blink in SET_SEC.
        do_reset();
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        check("blink_on", 64'(a_disp24()), 64'h1234FF);
        check("blink_off_b", 64'(b_disp24()), 64'h123456);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("blink_restore", 64'(a_disp24()), 64'h123456);
        step(1, 0, 0, 0);
        check("blink_on2", 64'(a_disp24()), 64'h1234FF);
        check("blink_off_b2", 64'(b_disp24()), 64'h123456);

        // Conflicts.
        do_reset();
        step(1, 1, 0, 0);
        check("tick_on_mode", 64'(a_cen), 64'd0);
        step(0, 0, 1, 1);
        check("inc_dec_same", 64'({a_dsp[5], a_dsp[4]}), 64'h12);
        step(0, 1, 1, 0);
        check("mode_inc_sf", 64'(a_sf), 64'd2);
        check("mode_inc_hr", 64'({a_dsp[5], a_dsp[4]}), 64'h12);
        async_reset();
        check("rst_mid_sf", 64'(a_sf), 64'd0);
        check("rst_mid_load", 64'(a_ld), 64'd0);

        // Non-BCD capture.
        do_reset();
        live[0] = 4'hB;
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("nonbcd_capture", 64'({a_dsp[1], a_dsp[0]}), 64'h5B);
        step(0, 0, 1, 0);
        check("nonbcd_inc", 64'({a_dsp[1], a_dsp[0]}), 64'h00);

        // Randomized traffic against the model.
        do_reset();
        set_live(12, 34, 56);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0)
                set_live($urandom_range(0, 23), $urandom_range(0, 59),
                         $urandom_range(0, 59));
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
                step(0, 0, 0, 0);
                rst_n = 1'b1;
            end
            step($urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
        end

        check("load_q_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
